// File: rtl/mem_arbiter.sv
// mem_arbiter
//   Shares one memory port between the instruction fetch unit (IFU) and the
//   load/store unit (LSU). Exactly one transaction is in flight at a time:
//   grant in IDLE, present the request in REQ, wait for the response in WAIT,
//   and return the captured data to the owner for one cycle in RESP.
//
//   Optional feature: define MEM_ARB_ROUND_ROBIN_EN to replace fixed LSU
//   priority with round-robin arbitration under contention.
//
// Ports
//   clk, rst                      clock, synchronous active-high reset
//   ifu_req_valid/ready, ifu_addr IFU read request handshake
//   ifu_rsp_valid, ifu_rdata      IFU response pulse and held read data
//   lsu_req_valid/ready           LSU request handshake
//   lsu_addr/wen/wdata/wmask      LSU request fields
//   lsu_rsp_valid, lsu_rdata      LSU completion pulse, read data (0 on write)
//   mem_req_valid/ready           memory request handshake (valid registered)
//   mem_addr/wen/wdata/wmask      memory request fields, held through REQ
//   mem_rsp_valid, mem_rdata      memory response
module mem_arbiter #(
  parameter int ADDR_W = 64,
  parameter int DATA_W = 64,
  parameter int MASK_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ifu_req_valid,
  output logic              ifu_req_ready,
  input  logic [ADDR_W-1:0] ifu_addr,
  output logic              ifu_rsp_valid,
  output logic [DATA_W-1:0] ifu_rdata,
  input  logic              lsu_req_valid,
  output logic              lsu_req_ready,
  input  logic [ADDR_W-1:0] lsu_addr,
  input  logic              lsu_wen,
  input  logic [DATA_W-1:0] lsu_wdata,
  input  logic [MASK_W-1:0] lsu_wmask,
  output logic              lsu_rsp_valid,
  output logic [DATA_W-1:0] lsu_rdata,
  output logic              mem_req_valid,
  input  logic              mem_req_ready,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_wen,
  output logic [DATA_W-1:0] mem_wdata,
  output logic [MASK_W-1:0] mem_wmask,
  input  logic              mem_rsp_valid,
  input  logic [DATA_W-1:0] mem_rdata
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} state_t;

  state_t state, state_nxt;
  logic   owner;     // 0 = IFU, 1 = LSU
  logic   pick_lsu;  // LSU wins when both requesters are valid
  logic   accept;

`ifdef MEM_ARB_ROUND_ROBIN_EN
  logic last_grant;  // 0 = IFU, 1 = LSU

  always_ff @(posedge clk) begin
    if (rst) begin
      last_grant <= 1'b0;
    end else if (accept) begin
      last_grant <= lsu_req_ready;
    end
  end

  assign pick_lsu = ~last_grant;
`else
  assign pick_lsu = 1'b1;
`endif

  assign accept = ifu_req_ready | lsu_req_ready;

  always_comb begin
    ifu_req_ready = 1'b0;
    lsu_req_ready = 1'b0;
    state_nxt     = state;
    case (state)
      IDLE: begin
        // Ready is withheld during reset so nothing is accepted that cycle.
        if (!rst) begin
          if (lsu_req_valid && (!ifu_req_valid || pick_lsu)) begin
            lsu_req_ready = 1'b1;
          end else if (ifu_req_valid) begin
            ifu_req_ready = 1'b1;
          end
          if (ifu_req_valid || lsu_req_valid) begin
            state_nxt = REQ;
          end
        end
      end
      REQ:     if (mem_req_ready) state_nxt = WAIT;
      WAIT:    if (mem_rsp_valid) state_nxt = RESP;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      owner         <= 1'b0;
      mem_req_valid <= 1'b0;
      mem_addr      <= '0;
      mem_wen       <= 1'b0;
      mem_wdata     <= '0;
      mem_wmask     <= '0;
      ifu_rdata     <= '0;
      lsu_rdata     <= '0;
    end else begin
      state <= state_nxt;
      // IFU requests are always reads: no write enable, mask or data.
      if (accept) begin
        owner         <= lsu_req_ready;
        mem_req_valid <= 1'b1;
        mem_addr      <= lsu_req_ready ? lsu_addr : ifu_addr;
        mem_wen       <= lsu_req_ready & lsu_wen;
        mem_wdata     <= lsu_req_ready ? lsu_wdata : '0;
        mem_wmask     <= (lsu_req_ready && lsu_wen) ? lsu_wmask : '0;
      end
      if (state == REQ && mem_req_ready) begin
        mem_req_valid <= 1'b0;
      end
      // Only the owner's data register moves; the other keeps its last value.
      if (state == WAIT && mem_rsp_valid) begin
        if (owner) begin
          lsu_rdata <= mem_wen ? '0 : mem_rdata;
        end else begin
          ifu_rdata <= mem_rdata;
        end
      end
    end
  end

  assign ifu_rsp_valid = (state == RESP) && !owner;
  assign lsu_rsp_valid = (state == RESP) &&  owner;

endmodule
